// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame host: FSM state encoding,
// default frame length, byte-index width and the SPI mode-0 clocking constants.
package spi_frame_pkg;

    localparam int NBYTES_DEFAULT = 20;
    localparam int BYTE_IDX_W     = 5;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SCK_HI   = 3'd2,
        SCK_LO   = 3'd3,
        HOLD     = 3'd4,
        GAP_WAIT = 3'd5
    } state_e;

endpackage

// File: rtl/spi_frame_bitclk.sv
// SCK phase timer: counts CLK_DIV clk cycles per SCK half-period and flags the
// last cycle of each phase as rise / fall / sample strobes for the frame FSM.
module spi_frame_bitclk
    import spi_frame_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic hi,
    output logic rise,
    output logic fall,
    output logic sample
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    always_comb begin
        last  = (cnt_q == CW'(CLK_DIV - 1));
        cnt_d = cnt_q;
        if (!en || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Mode 0 samples at the end of the high phase, just before SCK falls.
    assign rise   = en && last && !hi;
    assign fall   = en && last && hi;
    assign sample = en && last && (hi != CPHA);

endmodule

// File: rtl/spi_frame_host.sv
// SPI mode-0 master clocking fixed-length frames, MSB first, with registered outputs.
// Optional SPI_FRAME_HOST_AUTO_EN: back-to-back frames while auto=1.
module spi_frame_host
    import spi_frame_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int NBYTES  = NBYTES_DEFAULT,
    parameter int GAP     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  auto,
    output logic [BYTE_IDX_W-1:0] tx_addr,
    input  logic [7:0]            tx_data,
    output logic                  rx_valid,
    output logic [BYTE_IDX_W-1:0] rx_addr,
    output logic [7:0]            rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  SSEL,
    output logic                  SCK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int IW = BYTE_IDX_W;
    localparam int GW = $clog2(GAP + 1);

    state_e        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] byte_cnt_q, byte_cnt_d;
    logic [6:0]    tx_sr_q, tx_sr_d;
    logic [6:0]    rx_sr_q, rx_sr_d;
    logic [IW-1:0] tx_addr_q, tx_addr_d;
    logic [IW-1:0] rx_addr_q, rx_addr_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          mosi_q, mosi_d;
    logic          ssel_q, ssel_d;
    logic          sck_q, sck_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic bit_en, bit_hi, rise, fall, sample;
    logic in_gap_state, gap_last, frame_end, auto_go, load_first;

    `ifdef SPI_FRAME_HOST_AUTO_EN
    assign auto_go = auto;
    `else
    logic auto_unused;
    assign auto_unused = auto;
    assign auto_go     = 1'b0;
    `endif

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(NBYTES - 1)) ? idx : idx + 1'b1;
    endfunction

    assign bit_hi       = (state_q == SCK_HI);
    assign bit_en       = bit_hi || (state_q == SCK_LO);
    assign in_gap_state = (state_q == SETUP) || (state_q == HOLD) || (state_q == GAP_WAIT);
    assign gap_last     = (gap_cnt_q == GW'(GAP - 1));
    assign frame_end    = (byte_cnt_q == IW'(NBYTES));

    spi_frame_bitclk #(
        .CLK_DIV (CLK_DIV)
    ) u_bitclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (bit_en),
        .hi     (bit_hi),
        .rise   (rise),
        .fall   (fall),
        .sample (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start)    state_d = SETUP;
            SETUP:    if (gap_last) state_d = SCK_HI;
            SCK_HI:   if (fall)     state_d = SCK_LO;
            SCK_LO:   if (rise)     state_d = frame_end ? HOLD : SCK_HI;
            HOLD:     if (gap_last) state_d = GAP_WAIT;
            GAP_WAIT: if (gap_last) state_d = auto_go ? SETUP : IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        gap_cnt_d  = '0;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        tx_addr_d  = tx_addr_q;
        rx_addr_d  = rx_addr_q;
        rx_data_d  = rx_data_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        load_first = 1'b0;

        if (in_gap_state && !gap_last) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_addr_d  = '0;
                load_first = start;
            end
            SCK_HI: begin
                if (sample) begin
                    rx_sr_d = {rx_sr_q[5:0], MISO};
                end
                if (fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        // Byte boundary: publish rx byte and fetch the next tx byte,
                        // whose address has been stable for the whole byte.
                        rx_data_d  = {rx_sr_q, MISO};
                        rx_addr_d  = byte_cnt_q;
                        rx_valid_d = 1'b1;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        bit_cnt_d  = 3'd7;
                        tx_sr_d    = tx_data[6:0];
                        mosi_d     = tx_data[7];
                        tx_addr_d  = next_idx(tx_addr_q);
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        tx_sr_d   = {tx_sr_q[5:0], 1'b0};
                        mosi_d    = tx_sr_q[6];
                    end
                end
            end
            HOLD: begin
                tx_addr_d = '0;
                mosi_d    = 1'b0;
            end
            GAP_WAIT: begin
                tx_addr_d  = '0;
                load_first = gap_last && auto_go;
            end
            default: ;
        endcase

        if (load_first) begin
            tx_sr_d    = tx_data[6:0];
            mosi_d     = tx_data[7];
            byte_cnt_d = '0;
            bit_cnt_d  = 3'd7;
            tx_addr_d  = next_idx('0);
        end
    end

    // Pin-level outputs follow the next state so they line up with state_q.
    always_comb begin
        ssel_d = (state_d == IDLE) || (state_d == GAP_WAIT);
        sck_d  = (state_d == SCK_HI) ? ~CPOL : CPOL;
        busy_d = (state_d != IDLE);
        done_d = (state_d == GAP_WAIT) && (gap_cnt_d == GW'(GAP - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q  <= '0;
            bit_cnt_q  <= 3'd7;
            byte_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            tx_addr_q  <= '0;
            rx_addr_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            ssel_q     <= 1'b1;
            sck_q      <= CPOL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            gap_cnt_q  <= gap_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            tx_addr_q  <= tx_addr_d;
            rx_addr_q  <= rx_addr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            mosi_q     <= mosi_d;
            ssel_q     <= ssel_d;
            sck_q      <= sck_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_addr  = tx_addr_q;
    assign rx_addr  = rx_addr_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign SSEL     = ssel_q;
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_frame_host.sv
// Scoreboard bench for spi_frame_host: loopback frames, edge timing, start
// filtering, mid-frame reset, CLK_DIV=2 instance and (if enabled) auto repeat.
module tb_spi_frame_host;

    localparam int CLK_DIV   = 4;
    localparam int NB        = 20;
    localparam int GAP       = 8;
    localparam int FRAME_CYC = 1 + GAP + NB * 16 * CLK_DIV + 2 * GAP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, auto_en;
    logic [4:0] tx_addr, rx_addr;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, busy, done, ssel, sck, mosi, miso;

    logic       start2;
    logic [4:0] tx_addr2, rx_addr2;
    logic [7:0] tx_data2, rx_data2;
    logic       rx_valid2, busy2, done2, ssel2, sck2, mosi2;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [12:0] rx_exp_q[$];
    logic [12:0] rx2_exp_q[$];
    int          done_exp_q[$];
    logic [12:0] mon_e;
    logic [12:0] mon2_e;
    int          mon_d;

    assign tx_data  = 8'(3 * int'(tx_addr) + 1);
    assign miso     = mosi;
    assign tx_data2 = {3'b000, tx_addr2};

    spi_frame_host u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .auto     (auto_en),
        .tx_addr  (tx_addr),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_addr  (rx_addr),
        .rx_data  (rx_data),
        .busy     (busy),
        .done     (done),
        .SSEL     (ssel),
        .SCK      (sck),
        .MOSI     (mosi),
        .MISO     (miso)
    );

    spi_frame_host #(.CLK_DIV(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .auto     (1'b0),
        .tx_addr  (tx_addr2),
        .tx_data  (tx_data2),
        .rx_valid (rx_valid2),
        .rx_addr  (rx_addr2),
        .rx_data  (rx_data2),
        .busy     (busy2),
        .done     (done2),
        .SSEL     (ssel2),
        .SCK      (sck2),
        .MOSI     (mosi2),
        .MISO     (1'b1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input int done_at);
        for (int k = 0; k < NB; k++) rx_exp_q.push_back({5'(k), 8'(3 * k + 1)});
        done_exp_q.push_back(done_at);
    endtask

    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (rx_exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL rx_unexpected: rx_addr=%0d rx_data=%0d with nothing pending", rx_addr, rx_data);
            end else begin
                mon_e = rx_exp_q.pop_front();
                check("rx_addr", int'(rx_addr), int'(mon_e[12:8]));
                check("rx_data", int'(rx_data), int'(mon_e[7:0]));
            end
        end
        if (rst_n && done) begin
            if (done_exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL done_unexpected: done at cycle %0d with no frame pending", cyc);
            end else begin
                mon_d = done_exp_q.pop_front();
                check("done_cycle", cyc, mon_d);
            end
        end
        if (rst_n && rx_valid2) begin
            if (rx2_exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL rx2_unexpected: rx_addr=%0d rx_data=%0d", rx_addr2, rx_data2);
            end else begin
                mon2_e = rx2_exp_q.pop_front();
                check("rx2_addr", int'(rx_addr2), int'(mon2_e[12:8]));
                check("rx2_data", int'(rx_data2), int'(mon2_e[7:0]));
            end
        end
    end

    // One default-DUT frame with edge bookkeeping; optional stray start at iteration repulse.
    task automatic run_frame(input int repulse, output int rises, output int first_rise,
                             output int ssel_fall, output int done_len);
        int   c0;
        logic psck, pssel;
        @(negedge clk);
        start = 1'b1;
        c0    = cyc;
        push_frame(c0 + FRAME_CYC - 1);
        rises = 0; first_rise = -1; ssel_fall = -1; done_len = 0;
        psck = sck; pssel = ssel;
        for (int i = 1; i <= FRAME_CYC + 200 && done_len == 0; i++) begin
            @(negedge clk);
            start = (i == repulse);
            if (!ssel && pssel) ssel_fall = cyc;
            if (sck && !psck) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
            end
            if (done) done_len = cyc - c0 + 1;
            psck  = sck;
            pssel = ssel;
        end
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, fr, sf, dl, cnt, c0, lf, min_hi, max_hi, min_lo, max_lo, hi_run, lo_run;
        logic seen, p;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; auto_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ssel", int'(ssel), 1);
        check("rst_sck", int'(sck), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_addr", int'(rx_addr), 0);
        check("rst_tx_addr", int'(tx_addr), 0);
        check("rst_ssel2", int'(ssel2), 1);
        check("rst_mosi2", int'(mosi2), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Loopback frame: 160 rises, 8 cycles of SSEL setup, 1305-cycle frame.
        run_frame(-1, rises, fr, sf, dl);
        check("sck_rises", rises, NB * 8);
        check("ssel_setup", fr - sf, GAP);
        check("frame_len", dl, FRAME_CYC);
        repeat (5) @(negedge clk);

        // Stray start mid-frame is ignored.
        `ifndef SPI_FRAME_HOST_AUTO_EN
        auto_en = 1'b1;
        `endif
        run_frame(99, rises, fr, sf, dl);
        check("repulse_frame_len", dl, FRAME_CYC);
        check("repulse_rises", rises, NB * 8);
        repeat (20) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_ssel", int'(ssel), 1);
        auto_en = 1'b0;

        // Reset during byte 7.
        @(negedge clk);
        start = 1'b1;
        push_frame(cyc + FRAME_CYC - 1);
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (rx_valid && rx_addr == 5'd6) seen = 1'b1;
        end
        check("byte6_reached", int'(seen), 1);
        repeat (20) @(negedge clk);
        check("pre_rst_ssel", int'(ssel), 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_ssel", int'(ssel), 1);
        check("async_rst_sck", int'(sck), 0);
        check("async_rst_busy", int'(busy), 0);
        rx_exp_q.delete();
        done_exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_valid || done || !ssel) cnt++;
        end
        check("post_rst_quiet", cnt, 0);
        run_frame(-1, rises, fr, sf, dl);
        check("post_rst_frame_len", dl, FRAME_CYC);
        check("post_rst_rises", rises, NB * 8);
        repeat (5) @(negedge clk);

        // CLK_DIV=2 instance with MISO tied high.
        @(negedge clk);
        start2 = 1'b1;
        c0 = cyc;
        for (int k = 0; k < NB; k++) rx2_exp_q.push_back({5'(k), 8'hFF});
        fr = -1; lf = -1; rises = 0; dl = 0; p = sck2; cnt = 0;
        min_hi = 999; max_hi = 0; min_lo = 999; max_lo = 0; hi_run = 0; lo_run = 0;
        for (int i = 1; i <= 1000 && dl == 0; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (!busy2) cnt++;
            if (sck2 && !p) begin
                rises++;
                if (fr < 0) fr = cyc;
                else begin
                    if (lo_run < min_lo) min_lo = lo_run;
                    if (lo_run > max_lo) max_lo = lo_run;
                end
                hi_run = 1;
            end else if (sck2) begin
                hi_run++;
            end else if (p) begin
                if (hi_run < min_hi) min_hi = hi_run;
                if (hi_run > max_hi) max_hi = hi_run;
                lf = cyc;
                lo_run = 1;
            end else if (fr >= 0) begin
                lo_run++;
            end
            if (done2) dl = cyc - c0 + 1;
            p = sck2;
        end
        check("div2_rises", rises, NB * 8);
        check("div2_span", lf - fr, NB * 16 * 2 - 2);
        check("div2_hi_min", min_hi, 2);
        check("div2_hi_max", max_hi, 2);
        check("div2_lo_min", min_lo, 2);
        check("div2_lo_max", max_lo, 2);
        check("div2_frame_len", dl, 1 + GAP + NB * 16 * 2 + 2 * GAP);
        check("div2_busy_gaps", cnt, 0);
        repeat (5) @(negedge clk);

        `ifdef SPI_FRAME_HOST_AUTO_EN
        // Auto repeat: three back-to-back frames, auto dropped during the third.
        auto_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        for (int f = 0; f < 3; f++) push_frame(c0 + (f + 1) * (FRAME_CYC - 1));
        cnt = 0; rises = 0; lf = 0; hi_run = 0; min_hi = 999; max_hi = 0; lo_run = 0;
        p = ssel;
        for (int i = 1; i <= 3 * FRAME_CYC + 100 && rises < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) cnt++;
            if (done) begin
                rises++;
                lf = cyc;
            end
            if (rises == 2 && cyc > lf + 100) auto_en = 1'b0;
            if (ssel && !p) hi_run = 1;
            else if (ssel && hi_run > 0) hi_run++;
            else if (!ssel && p && hi_run > 0) begin
                lo_run++;
                if (hi_run < min_hi) min_hi = hi_run;
                if (hi_run > max_hi) max_hi = hi_run;
                hi_run = 0;
            end
            p = ssel;
        end
        check("auto_dones", rises, 3);
        check("auto_busy_drops", cnt, 0);
        check("auto_gap_count", lo_run, 2);
        check("auto_gap_min", min_hi, GAP);
        check("auto_gap_max", max_hi, GAP);
        repeat (20) @(negedge clk);
        check("auto_off_idle", int'(busy), 0);
        `endif

        repeat (5) @(negedge clk);
        check("rx_queue_empty", rx_exp_q.size(), 0);
        check("rx2_queue_empty", rx2_exp_q.size(), 0);
        check("done_queue_empty", done_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
